// File: rtl/conf_int_mac_pkg.sv
// Shared definitions for the pipelined configurable-precision integer MAC.
//   - mac_state_e   : group-tracking FSM states (IDLE, ACCUM)
//   - clamp_prec()  : maps the runtime prec port onto the effective precision
//   - sat_*_limit() : two's-complement saturation limits for a given width,
//                     used by the top when CONF_INT_MAC_SAT_EN is defined
package conf_int_mac_pkg;

    localparam int unsigned DP_W_DEFAULT   = 32;
    localparam int unsigned OP_W_DEFAULT   = 32;
    localparam int unsigned ACC_W_DEFAULT  = 72;
    localparam int unsigned PREC_W_DEFAULT = 6;

    // Widest data path the saturation helpers can describe.
    localparam int unsigned SAT_MAX_W = 128;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } mac_state_e;

    // prec = 0 selects full precision; anything above op_bw is clamped.
    function automatic int unsigned clamp_prec(input int unsigned prec,
                                               input int unsigned op_bw);
        if (prec == 0 || prec > op_bw) begin
            return op_bw;
        end
        return prec;
    endfunction

    // Largest positive value of a w-bit signed number (0x7F..F), zero-padded.
    function automatic logic [SAT_MAX_W-1:0] sat_pos_limit(input int unsigned w);
        logic [SAT_MAX_W-1:0] r;
        for (int unsigned i = 0; i < SAT_MAX_W; i++) begin
            r[i] = (i + 1 < w);
        end
        return r;
    endfunction

    // Most negative value of a w-bit signed number (0x80..0), zero-padded.
    function automatic logic [SAT_MAX_W-1:0] sat_neg_limit(input int unsigned w);
        logic [SAT_MAX_W-1:0] r;
        for (int unsigned i = 0; i < SAT_MAX_W; i++) begin
            r[i] = (i + 1 == w);
        end
        return r;
    endfunction

endpackage

// File: rtl/conf_int_mac_acc_pipe_prec_mask.sv
// Combinational operand masker: keeps the top `prec` bits of `din` and clears
// the low (DATA_W - prec) bits (two's-complement truncation toward -inf).
//   din  : operand in
//   prec : effective precision, already clamped to 1..DATA_W
//   dout : masked operand
module conf_int_prec_mask #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PREC_W = 6
) (
    input  logic [DATA_W-1:0] din,
    input  logic [PREC_W-1:0] prec,
    output logic [DATA_W-1:0] dout
);

    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            // Bit i survives when it lies within the top `prec` bits.
            if (i + 32'(prec) >= DATA_W) begin
                dout[i] = din[i];
            end
        end
    end

endmodule

// File: rtl/conf_int_mac_acc_pipe.sv
// Pipelined, runtime-configurable-precision integer multiply-accumulate.
// Beats of an accumulation group stream in on a valid/ready handshake; the
// group result (c_in of the first beat plus the sum of masked products) is
// emitted on d with an overflow flag.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input beat handshake
//   a, b, c_in          : signed operands / addend (addend used on first beat)
//   in_last             : closes the accumulation group
//   prec                : effective precision, sampled on the first beat
//   out_valid/out_ready : result handshake
//   d, overflow         : result (wrapped or saturated) and overflow flag
//
// Build option: define CONF_INT_MAC_SAT_EN to saturate d on overflow instead
// of wrapping.
//
// Timing: S1 (masked operands) -> S2 (product) -> S3 (accumulator) -> output
// register; a last beat accepted at edge N shows out_valid after edge N+3.
module conf_int_mac_acc_pipe
    import conf_int_mac_pkg::*;
#(
    parameter int unsigned DATA_PATH_BITWIDTH = DP_W_DEFAULT,
    parameter int unsigned OP_BITWIDTH        = OP_W_DEFAULT,
    parameter int unsigned ACC_BITWIDTH       = ACC_W_DEFAULT,
    parameter int unsigned PREC_W             = PREC_W_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    input  logic [DATA_PATH_BITWIDTH-1:0] c_in,
    input  logic                          in_last,
    input  logic [PREC_W-1:0]             prec,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] d,
    output logic                          overflow
);

    localparam int unsigned W  = DATA_PATH_BITWIDTH;
    localparam int unsigned PW = 2 * DATA_PATH_BITWIDTH;
    localparam int unsigned AW = ACC_BITWIDTH;

    // ------------------------------------------------------------------
    // Handshake / global advance
    // ------------------------------------------------------------------
    logic adv;
    logic accept;
    logic out_valid_q, out_valid_d;
    logic [W-1:0] d_q, d_d;
    logic overflow_q, overflow_d;

    assign adv      = !(out_valid_q && !out_ready);
    assign in_ready = adv && !rst;
    assign accept   = in_valid && in_ready;

    // Outputs read as idle while reset is held, even before the first edge.
    assign out_valid = out_valid_q && !rst;
    assign d         = rst ? '0 : d_q;
    assign overflow  = overflow_q && !rst;

    // ------------------------------------------------------------------
    // Group-tracking FSM and precision latch (accept-time view)
    // ------------------------------------------------------------------
    mac_state_e        state_q, state_d;
    logic [PREC_W-1:0] prec_q, prec_d;
    logic [PREC_W-1:0] p_cur;
    logic              beat_first;

    always_comb begin
        state_d    = state_q;
        prec_d     = prec_q;
        beat_first = (state_q == IDLE);
        p_cur      = beat_first ? PREC_W'(clamp_prec(32'(prec), OP_BITWIDTH))
                                : prec_q;
        if (accept) begin
            if (beat_first) begin
                prec_d = p_cur;
            end
            state_d = in_last ? IDLE : ACCUM;
        end
    end

    // ------------------------------------------------------------------
    // Operand masking
    // ------------------------------------------------------------------
    logic [W-1:0] a_masked;
    logic [W-1:0] b_masked;

    conf_int_prec_mask #(
        .DATA_W (W),
        .PREC_W (PREC_W)
    ) u_mask_a (
        .din  (a),
        .prec (p_cur),
        .dout (a_masked)
    );

    conf_int_prec_mask #(
        .DATA_W (W),
        .PREC_W (PREC_W)
    ) u_mask_b (
        .din  (b),
        .prec (p_cur),
        .dout (b_masked)
    );

    // ------------------------------------------------------------------
    // Pipeline stages
    // ------------------------------------------------------------------
    logic          s1_valid_q, s1_valid_d;
    logic [W-1:0]  s1_a_q, s1_a_d;
    logic [W-1:0]  s1_b_q, s1_b_d;
    logic [W-1:0]  s1_c_q, s1_c_d;
    logic          s1_first_q, s1_first_d;
    logic          s1_last_q, s1_last_d;

    logic          s2_valid_q, s2_valid_d;
    logic [PW-1:0] s2_prod_q, s2_prod_d;
    logic [W-1:0]  s2_c_q, s2_c_d;
    logic          s2_first_q, s2_first_d;
    logic          s2_last_q, s2_last_d;

    logic          s3_valid_q, s3_valid_d;
    logic          s3_last_q, s3_last_d;
    logic [AW-1:0] acc_q, acc_d;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [AW-1:0] prod_sext;
    logic [AW-1:0] c_sext;
    logic          acc_fits;
    logic          result_here;

    always_comb begin
        // Sign-extended 2W x 2W multiply; the low 2W bits are the exact
        // signed W x W product.
        a_ext     = {{W{s1_a_q[W-1]}}, s1_a_q};
        b_ext     = {{W{s1_b_q[W-1]}}, s1_b_q};
        prod_sext = {{(AW-PW){s2_prod_q[PW-1]}}, s2_prod_q};
        c_sext    = {{(AW-W){s2_c_q[W-1]}}, s2_c_q};

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_c_d     = s1_c_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_prod_d  = s2_prod_q;
        s2_c_d     = s2_c_q;
        s2_first_d = s2_first_q;
        s2_last_d  = s2_last_q;
        s3_valid_d = s3_valid_q;
        s3_last_d  = s3_last_q;
        acc_d      = acc_q;

        if (adv) begin
            s1_valid_d = accept;
            s1_a_d     = a_masked;
            s1_b_d     = b_masked;
            s1_c_d     = c_in;
            s1_first_d = beat_first;
            s1_last_d  = in_last;

            s2_valid_d = s1_valid_q;
            s2_prod_d  = a_ext * b_ext;
            s2_c_d     = s1_c_q;
            s2_first_d = s1_first_q;
            s2_last_d  = s1_last_q;

            s3_valid_d = s2_valid_q;
            s3_last_d  = s2_last_q;
            if (s2_valid_q) begin
                acc_d = s2_first_q ? (c_sext + prod_sext) : (acc_q + prod_sext);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_comb begin
        acc_fits    = (acc_q[AW-1:W-1] == '0) || (acc_q[AW-1:W-1] == '1);
        result_here = s3_valid_q && s3_last_q;
        out_valid_d = out_valid_q;
        d_d         = d_q;
        overflow_d  = overflow_q;
        if (adv) begin
            out_valid_d = result_here;
            if (result_here) begin
                overflow_d = !acc_fits;
`ifdef CONF_INT_MAC_SAT_EN
                if (!acc_fits) begin
                    d_d = acc_q[AW-1] ? W'(sat_neg_limit(W)) : W'(sat_pos_limit(W));
                end else begin
                    d_d = acc_q[W-1:0];
                end
`else
                d_d = acc_q[W-1:0];
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prec_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_c_q      <= '0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_prod_q   <= '0;
            s2_c_q      <= '0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            d_q         <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prec_q      <= prec_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_c_q      <= s1_c_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_prod_q   <= s2_prod_d;
            s2_c_q      <= s2_c_d;
            s2_first_q  <= s2_first_d;
            s2_last_q   <= s2_last_d;
            s3_valid_q  <= s3_valid_d;
            s3_last_q   <= s3_last_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            d_q         <= d_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_conf_int_mac_acc_pipe.sv
// Self-checking bench for conf_int_mac_acc_pipe: directed scenarios plus a
// randomized stream, each result checked against a group-level arithmetic
// model (c of first beat + sum of precision-truncated products).
module tb_conf_int_mac_acc_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c_in;
    logic        in_last;
    logic [5:0]  prec;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic        overflow;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int last_accept_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conf_int_mac_acc_pipe #(
        .DATA_PATH_BITWIDTH (32),
        .OP_BITWIDTH        (32),
        .ACC_BITWIDTH       (72),
        .PREC_W             (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .in_last   (in_last),
        .prec      (prec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .overflow  (overflow)
    );

    // Expected and observed result streams.
    logic [31:0] exp_d_q[$];
    logic        exp_ovf_q[$];
    logic [31:0] obs_d_q[$];
    logic        obs_ovf_q[$];
    int          obs_cyc_q[$];

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            obs_d_q.push_back(d);
            obs_ovf_q.push_back(overflow);
            obs_cyc_q.push_back(cyc);
        end
    end

    // ---------------- reference model ----------------
    logic signed [127:0] m_sum;
    int                  m_prec;
    bit                  m_in_group = 1'b0;

    function automatic int p_eff_of(input logic [5:0] p);
        if (p == 6'd0 || p > 6'd32) return 32;
        return int'(p);
    endfunction

    // Truncate toward -inf to p significant bits: floor(v / 2^s) * 2^s.
    function automatic logic signed [127:0] trunc_op(input logic [31:0] v, input int p);
        logic signed [127:0] x;
        int s;
        x = 128'($signed(v));
        s = 32 - p;
        x = x >>> s;
        x = x <<< s;
        return x;
    endfunction

    task automatic model_accept(input logic [31:0] aa, input logic [31:0] bb,
                                input logic [31:0] cc, input logic lst,
                                input logic [5:0] pr);
        logic signed [127:0] prod;
        logic [31:0]         ed;
        bit                  eo;
        if (!m_in_group) begin
            m_prec = p_eff_of(pr);
            m_sum  = 128'($signed(cc));
        end
        prod  = trunc_op(aa, m_prec) * trunc_op(bb, m_prec);
        m_sum = m_sum + prod;
        if (lst) begin
            eo = (m_sum > 128'sd2147483647) || (m_sum < -128'sd2147483648);
            ed = m_sum[31:0];
`ifdef CONF_INT_MAC_SAT_EN
            if (eo) ed = (m_sum < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
            exp_d_q.push_back(ed);
            exp_ovf_q.push_back(eo);
            m_in_group = 1'b0;
        end else begin
            m_in_group = 1'b1;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_beat(input logic [31:0] aa, input logic [31:0] bb,
                             input logic [31:0] cc, input logic lst,
                             input logic [5:0] pr);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        a        = aa;
        b        = bb;
        c_in     = cc;
        in_last  = lst;
        prec     = pr;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            last_accept_cyc = cyc;
            model_accept(aa, bb, cc, lst, pr);
        end else begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_beat: in_ready stuck at %b, required 1 within 200 cycles", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input string name);
        int k;
        k = 0;
        while (obs_d_q.size() < n && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (obs_d_q.size() < n) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s timeout: got %0d results, required %0d", name, obs_d_q.size(), n);
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        exp_d_q.delete();
        exp_ovf_q.delete();
        obs_d_q.delete();
        obs_ovf_q.delete();
        obs_cyc_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a = '0; b = '0; c_in = '0; in_last = 1'b0; prec = '0;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if ({in_ready, out_valid, overflow} !== 3'b000 || d !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_outputs: got in_ready=%b out_valid=%b ovf=%b d=%h, required 0 0 0 0",
                         in_ready, out_valid, overflow, d);
            end
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_plain_mac();
        int n;
        clear_queues();
        send_beat(32'd3, 32'd4, 32'd5, 1'b1, 6'd32);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== (i == 4)) begin
                tests_failed++;
                $display("FAIL plain_latency: after edge N+%0d out_valid=%b, required %b", i - 1, out_valid, (i == 4));
            end
        end
        n = exp_d_q.size();
        wait_results(n, "plain_mac");
        tests_run++;
        if (obs_d_q.size() > 0 && (obs_d_q[0] !== 32'd17 || obs_cyc_q[0] - last_accept_cyc !== 3)) begin
            tests_failed++;
            $display("FAIL plain_mac_const: got d=%0d lat=%0d, required 17 lat 3", obs_d_q[0], obs_cyc_q[0] - last_accept_cyc);
        end
        for (int i = 0; i < n && obs_d_q.size() > 0; i++) begin
            logic [31:0] od, ed;
            logic oo, eo;
            od = obs_d_q.pop_front(); oo = obs_ovf_q.pop_front(); void'(obs_cyc_q.pop_front());
            ed = exp_d_q.pop_front(); eo = exp_ovf_q.pop_front();
            tests_run++;
            if (od !== ed || oo !== eo) begin
                tests_failed++;
                $display("FAIL plain_mac[%0d]: got d=%h ovf=%b, required d=%h ovf=%b", i, od, oo, ed, eo);
            end
        end
    endtask

    task automatic test_precision();
        int n;
        clear_queues();
        send_beat(32'h0001_FFFF, 32'h0000_0002, 32'h0, 1'b1, 6'd16);
        send_beat(32'h0001_FFFF, 32'h0000_0002, 32'h0, 1'b1, 6'd31);
        send_beat(32'hFFFF_FFFB, 32'h0000_0007, 32'h3, 1'b1, 6'd0);
        send_beat(32'h1234_5678, 32'hFEDC_BA98, 32'h11, 1'b1, 6'd45);
        send_beat(32'h8765_4321, 32'h0F0F_F0F0, 32'h0, 1'b1, 6'd1);
        n = exp_d_q.size();
        wait_results(n, "precision");
        tests_run++;
        if (obs_d_q.size() > 1 && (obs_d_q[0] !== 32'h0 || obs_d_q[1] !== 32'h0003_FFFC)) begin
            tests_failed++;
            $display("FAIL precision_const: got %h %h, required 00000000 0003fffc", obs_d_q[0], obs_d_q[1]);
        end
        for (int i = 0; i < n && obs_d_q.size() > 0; i++) begin
            logic [31:0] od, ed;
            logic oo, eo;
            od = obs_d_q.pop_front(); oo = obs_ovf_q.pop_front(); void'(obs_cyc_q.pop_front());
            ed = exp_d_q.pop_front(); eo = exp_ovf_q.pop_front();
            tests_run++;
            if (od !== ed || oo !== eo) begin
                tests_failed++;
                $display("FAIL precision[%0d]: got d=%h ovf=%b, required d=%h ovf=%b", i, od, oo, ed, eo);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        clear_queues();
        for (int i = 1; i <= 4; i++) begin
            send_beat(32'(i), 32'(i), (i == 1) ? 32'd10 : 32'd99, (i == 4), 6'd32);
        end
        send_beat(32'd2, 32'd3, 32'd1, 1'b1, 6'd32);
        n = exp_d_q.size();
        wait_results(n, "back_to_back");
        tests_run++;
        if (obs_d_q.size() > 1 && (obs_d_q[0] !== 32'd40 || obs_d_q[1] !== 32'd7
                                   || obs_cyc_q[1] - obs_cyc_q[0] !== 1)) begin
            tests_failed++;
            $display("FAIL back_to_back_const: got %0d %0d gap=%0d, required 40 7 gap 1",
                     obs_d_q[0], obs_d_q[1], obs_cyc_q[1] - obs_cyc_q[0]);
        end
        for (int i = 0; i < n && obs_d_q.size() > 0; i++) begin
            logic [31:0] od, ed;
            logic oo, eo;
            od = obs_d_q.pop_front(); oo = obs_ovf_q.pop_front(); void'(obs_cyc_q.pop_front());
            ed = exp_d_q.pop_front(); eo = exp_ovf_q.pop_front();
            tests_run++;
            if (od !== ed || oo !== eo) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: got d=%h ovf=%b, required d=%h ovf=%b", i, od, oo, ed, eo);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        clear_queues();
        out_ready = 1'b0;
        fork
            begin
                send_beat(32'd1, 32'd2, 32'd3, 1'b0, 6'd32);
                send_beat(32'd4, 32'd5, 32'd0, 1'b1, 6'd32);
                send_beat(32'hFFFF_FFFD, 32'd7, 32'd100, 1'b1, 6'd32);
                send_beat(32'd6, 32'd6, 32'd0, 1'b0, 6'd32);
                send_beat(32'd1, 32'd1, 32'hFFFF_FFFF, 1'b1, 6'd32);
            end
            begin
                logic [31:0] held;
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 100 && !seen; k++) begin
                    @(negedge clk);
                    seen = (out_valid === 1'b1);
                end
                held = d;
                tests_run++;
                if (!seen) begin
                    tests_failed++;
                    $display("FAIL backpressure_wait: out_valid=%b, required 1 within 100 cycles", out_valid);
                end
                repeat (5) begin
                    @(negedge clk);
                    tests_run++;
                    if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== held) begin
                        tests_failed++;
                        $display("FAIL backpressure_hold: got out_valid=%b in_ready=%b d=%h, required 1 0 %h",
                                 out_valid, in_ready, d, held);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        n = exp_d_q.size();
        wait_results(n, "backpressure");
        tests_run++;
        if (obs_d_q.size() !== 3) begin
            tests_failed++;
            $display("FAIL backpressure_count: got %0d results, required 3", obs_d_q.size());
        end
        for (int i = 0; i < n && obs_d_q.size() > 0; i++) begin
            logic [31:0] od, ed;
            logic oo, eo;
            od = obs_d_q.pop_front(); oo = obs_ovf_q.pop_front(); void'(obs_cyc_q.pop_front());
            ed = exp_d_q.pop_front(); eo = exp_ovf_q.pop_front();
            tests_run++;
            if (od !== ed || oo !== eo) begin
                tests_failed++;
                $display("FAIL backpressure[%0d]: got d=%h ovf=%b, required d=%h ovf=%b", i, od, oo, ed, eo);
            end
        end
    endtask

    task automatic test_overflow();
        int n;
        clear_queues();
        send_beat(32'h7FFF_FFFF, 32'd2, 32'd0, 1'b1, 6'd32);
        send_beat(32'h8000_0000, 32'd2, 32'd0, 1'b1, 6'd32);
        send_beat(32'h7FFF_FFFF, 32'd1, 32'd0, 1'b1, 6'd32);
        send_beat(32'h8000_0000, 32'd1, 32'd0, 1'b1, 6'd32);
        send_beat(32'h7FFF_FFFF, 32'd1, 32'd1, 1'b1, 6'd32);
        send_beat(32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 6'd32);
        n = exp_d_q.size();
        wait_results(n, "overflow");
        tests_run++;
`ifdef CONF_INT_MAC_SAT_EN
        if (obs_d_q.size() > 0 && (obs_d_q[0] !== 32'h7FFF_FFFF || obs_ovf_q[0] !== 1'b1)) begin
`else
        if (obs_d_q.size() > 0 && (obs_d_q[0] !== 32'hFFFF_FFFE || obs_ovf_q[0] !== 1'b1)) begin
`endif
            tests_failed++;
            $display("FAIL overflow_const: got d=%h ovf=%b", obs_d_q[0], obs_ovf_q[0]);
        end
        for (int i = 0; i < n && obs_d_q.size() > 0; i++) begin
            logic [31:0] od, ed;
            logic oo, eo;
            od = obs_d_q.pop_front(); oo = obs_ovf_q.pop_front(); void'(obs_cyc_q.pop_front());
            ed = exp_d_q.pop_front(); eo = exp_ovf_q.pop_front();
            tests_run++;
            if (od !== ed || oo !== eo) begin
                tests_failed++;
                $display("FAIL overflow[%0d]: got d=%h ovf=%b, required d=%h ovf=%b", i, od, oo, ed, eo);
            end
        end
    endtask

    task automatic test_reset_mid_group();
        int n;
        clear_queues();
        send_beat(32'd5, 32'd5, 32'd9, 1'b0, 6'd32);
        send_beat(32'd6, 32'd6, 32'd0, 1'b0, 6'd32);
        rst        = 1'b1;
        m_in_group = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || d !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got out_valid=%b in_ready=%b d=%h, required 0 0 0", out_valid, in_ready, d);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL mid_reset_quiet: cycle %0d out_valid=%b, required 0", i, out_valid);
            end
        end
        @(posedge clk);
        #1;
        send_beat(32'd1, 32'd1, 32'd0, 1'b1, 6'd32);
        n = exp_d_q.size();
        wait_results(n, "mid_reset");
        tests_run++;
        if (obs_d_q.size() !== 1 || obs_d_q[0] !== 32'd1) begin
            tests_failed++;
            $display("FAIL mid_reset_result: got %0d results first=%h, required 1 result 00000001",
                     obs_d_q.size(), (obs_d_q.size() > 0) ? obs_d_q[0] : 32'hx);
        end
        for (int i = 0; i < n && obs_d_q.size() > 0; i++) begin
            logic [31:0] od, ed;
            logic oo, eo;
            od = obs_d_q.pop_front(); oo = obs_ovf_q.pop_front(); void'(obs_cyc_q.pop_front());
            ed = exp_d_q.pop_front(); eo = exp_ovf_q.pop_front();
            tests_run++;
            if (od !== ed || oo !== eo) begin
                tests_failed++;
                $display("FAIL mid_reset[%0d]: got d=%h ovf=%b, required d=%h ovf=%b", i, od, oo, ed, eo);
            end
        end
    endtask

    task automatic test_random();
        int n;
        bit done;
        clear_queues();
        done = 1'b0;
        fork
            begin
                for (int g = 0; g < 40; g++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int k = 0; k < len; k++) begin
                        logic [31:0] ra, rb;
                        ra = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 255)) - 32'd128;
                        rb = $urandom();
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                        send_beat(ra, rb, $urandom(), (k == len - 1), 6'($urandom_range(0, 63)));
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        n = exp_d_q.size();
        wait_results(n, "random");
        tests_run++;
        if (obs_d_q.size() !== 40) begin
            tests_failed++;
            $display("FAIL random_count: got %0d results, required 40", obs_d_q.size());
        end
        for (int i = 0; i < n && obs_d_q.size() > 0; i++) begin
            logic [31:0] od, ed;
            logic oo, eo;
            od = obs_d_q.pop_front(); oo = obs_ovf_q.pop_front(); void'(obs_cyc_q.pop_front());
            ed = exp_d_q.pop_front(); eo = exp_ovf_q.pop_front();
            tests_run++;
            if (od !== ed || oo !== eo) begin
                tests_failed++;
                $display("FAIL random[%0d]: got d=%h ovf=%b, required d=%h ovf=%b", i, od, oo, ed, eo);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_plain_mac();
        test_precision();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_mid_group();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
